// File: rtl/ntt_core_gf64_bsk_pkg.sv
// Shared types and default sizes for the BSK skew path in front of
// ntt_core_gf64_post_process.
package ntt_core_gf64_bsk_pkg;

   localparam int BSK_MOD_NTT_W = 64;
   localparam int BSK_PSI       = 4;
   localparam int BSK_R         = 2;
   localparam int BSK_GLWE_K_P1 = 2;

   // Largest skew applied to a key column (column g leaves g cycles late).
   localparam int BSK_SKEW_MAX  = BSK_GLWE_K_P1 - 1;

   typedef logic [BSK_MOD_NTT_W-1:0] bsk_word_t;
   typedef bsk_word_t [BSK_PSI-1:0][BSK_R-1:0][BSK_GLWE_K_P1-1:0] bsk_vect_t;

endpackage

// File: rtl/ntt_core_gf64_bsk_skew_fifo.sv
// Register FIFO holding whole BSK vectors. DEPTH must be a power of 2 (>=2)
// so the pointers wrap naturally; occupancy is kept one bit wider.
module ntt_core_gf64_bsk_skew_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             a_rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage write.
   // NOTE: the storage array has no reset; occupancy alone says which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ntt_core_gf64_bsk_skew.sv
// Buffers full BSK vectors and issues key column g exactly g cycles after
// column 0, so post-process sees the skewed pattern it expects.
// Optional protocol checking: define NTT_CORE_GF64_BSK_SKEW_ERROR_EN.
module ntt_core_gf64_bsk_skew
   import ntt_core_gf64_bsk_pkg::*;
#(
   parameter int MOD_NTT_W = BSK_MOD_NTT_W,
   parameter int PSI       = BSK_PSI,
   parameter int R         = BSK_R,
   parameter int GLWE_K_P1 = BSK_GLWE_K_P1,
   parameter int DEPTH     = 4
) (
   input  logic                                            clk,
   input  logic                                            a_rst_n,
   input  logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0][MOD_NTT_W-1:0] s_bsk,
   input  logic                                            s_vld,
   output logic                                            s_rdy,
   output logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0][MOD_NTT_W-1:0] bsk,
   output logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0]                bsk_vld,
   input  logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0]                bsk_rdy,
   output logic                                            error
);

   localparam int VECT_W = PSI * R * GLWE_K_P1 * MOD_NTT_W;

   typedef logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0][MOD_NTT_W-1:0] vect_t;

   vect_t             head;
   logic [VECT_W-1:0] head_flat;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              rdy_en;

   // Holds s_rdy low through reset and releases it on the first clock after.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) rdy_en <= 1'b0;
      else          rdy_en <= 1'b1;
   end

   assign s_rdy = rdy_en & ~full;
   assign push  = s_vld & s_rdy;
   // Lane [0][0] column 0 is the reference that governs pops.
   assign pop   = ~empty & bsk_rdy[0][0][0];

   ntt_core_gf64_bsk_skew_fifo #(
      .WIDTH (VECT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .push    (push),
      .pop     (pop),
      .din     (s_bsk),
      .head    (head_flat),
      .full    (full),
      .empty   (empty)
   );

   assign head = head_flat;

   // Column 0 comes straight from the FIFO head registers.
   for (genvar p = 0; p < PSI; p++) begin : g_c0_psi
      for (genvar r = 0; r < R; r++) begin : g_c0_r
         assign bsk[p][r][0]     = head[p][r][0];
         assign bsk_vld[p][r][0] = ~empty;
      end
   end

   // Column g rides a g-stage shift register that never stalls.
   for (genvar g = 1; g < GLWE_K_P1; g++) begin : g_col
      logic [g-1:0]                              vld_sr;
      logic [g-1:0][PSI-1:0][R-1:0][MOD_NTT_W-1:0] dat_sr;

      // Valid bits: loaded on a pop, shifted every cycle, flushed by reset.
      always_ff @(posedge clk or negedge a_rst_n) begin
         if (!a_rst_n) begin
            vld_sr <= '0;
         end else begin
            vld_sr[0] <= pop;
            for (int s = 1; s < g; s++) vld_sr[s] <= vld_sr[s-1];
         end
      end

      // Key words follow their valid bits; contents are only meaningful when valid.
      always_ff @(posedge clk) begin
         for (int p = 0; p < PSI; p++) begin
            for (int r = 0; r < R; r++) begin
               dat_sr[0][p][r] <= head[p][r][g];
            end
         end
         for (int s = 1; s < g; s++) dat_sr[s] <= dat_sr[s-1];
      end

      for (genvar p = 0; p < PSI; p++) begin : g_psi
         for (genvar r = 0; r < R; r++) begin : g_r
            assign bsk[p][r][g]     = dat_sr[g-1][p][r];
            assign bsk_vld[p][r][g] = vld_sr[g-1];
         end
      end
   end

`ifdef NTT_CORE_GF64_BSK_SKEW_ERROR_EN
   logic err_d;

   // Flags lane disagreement on column 0 and any skewed word presented while not ready.
   always_comb begin
      // NOTE: assigning a default first keeps this block free of inferred latches.
      err_d = 1'b0;
      for (int p = 0; p < PSI; p++) begin
         for (int r = 0; r < R; r++) begin
            if (!empty && (bsk_rdy[p][r][0] != bsk_rdy[0][0][0])) err_d = 1'b1;
            for (int g = 1; g < GLWE_K_P1; g++) begin
               if (bsk_vld[p][r][g] && !bsk_rdy[p][r][g]) err_d = 1'b1;
            end
         end
      end
   end

   // One-cycle error pulse, one cycle after the offending cycle.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) error <= 1'b0;
      else          error <= err_d;
   end
`else
   // Only the reference ready is consumed when checking is compiled out.
   logic unused_rdy;
   assign unused_rdy = ^bsk_rdy;
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_core_gf64_bsk_skew.sv
// Self-checking bench for ntt_core_gf64_bsk_skew: directed table, streaming,
// mid-stream reset and randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_ntt_core_gf64_bsk_skew;
   import ntt_core_gf64_bsk_pkg::*;

   localparam int PSI   = BSK_PSI;
   localparam int R     = BSK_R;
   localparam int K     = BSK_GLWE_K_P1;
   localparam int DEPTH = 4;
   localparam int VW    = $bits(bsk_vect_t);
`ifdef NTT_CORE_GF64_BSK_SKEW_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef logic [PSI-1:0][R-1:0][K-1:0] lane_bits_t;

   typedef struct {
      bit s_vld;
      int vid;
      bit r_ref;      // column-0 ready on every lane except [3][1]
      bit r_3_1;      // column-0 ready on lane [3][1]
      bit r_1_0_g1;   // column-1 ready on lane [1][0]
      bit exp_s_rdy;
      bit exp_v0;
      bit exp_v1;
      bit exp_err;    // error pulse expected when checking is compiled in
   } row_t;

   logic       clk = 1'b0;
   logic       a_rst_n = 1'b1;
   bsk_vect_t  s_bsk;
   logic       s_vld;
   logic       s_rdy;
   bsk_vect_t  bsk;
   lane_bits_t bsk_vld;
   lane_bits_t bsk_rdy;
   logic       error;

   always #5 clk = ~clk;

   ntt_core_gf64_bsk_skew #(
      .MOD_NTT_W (BSK_MOD_NTT_W),
      .PSI       (PSI),
      .R         (R),
      .GLWE_K_P1 (K),
      .DEPTH     (DEPTH)
   ) dut (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .s_bsk   (s_bsk),
      .s_vld   (s_vld),
      .s_rdy   (s_rdy),
      .bsk     (bsk),
      .bsk_vld (bsk_vld),
      .bsk_rdy (bsk_rdy),
      .error   (error)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: FIFO contents, pop history by cycle, pending error.
   bsk_vect_t q[$];
   bit        pop_at[int];
   bsk_vect_t pop_v[int];
   bit        rdy_en_m = 1'b0;
   bit        viol_prev = 1'b0;
   int        cyc = 0;

   function automatic bsk_vect_t rand_vec();
      bsk_vect_t v;
      for (int p = 0; p < PSI; p++)
         for (int r = 0; r < R; r++)
            for (int g = 0; g < K; g++)
               v[p][r][g] = bsk_word_t'({$urandom(), $urandom()});
      return v;
   endfunction

   // Compares all outputs with the model for the current cycle, then advances one clock.
   task automatic tick();
      bit         exp_srdy, viol, push, pop;
      lane_bits_t exp_vld;
      bsk_vect_t  exp_dat, mask, hd, pv;
      #1;
      exp_srdy = rdy_en_m && (q.size() < DEPTH);
      exp_vld = '0; exp_dat = '0; mask = '0;
      if (q.size() > 0) begin
         hd = q[0];
         for (int p = 0; p < PSI; p++)
            for (int r = 0; r < R; r++) begin
               exp_vld[p][r][0] = 1'b1;
               exp_dat[p][r][0] = hd[p][r][0];
               mask[p][r][0]    = '1;
            end
      end
      for (int g = 1; g < K; g++) begin
         if (pop_at.exists(cyc - g)) begin
            pv = pop_v[cyc - g];
            for (int p = 0; p < PSI; p++)
               for (int r = 0; r < R; r++) begin
                  exp_vld[p][r][g] = 1'b1;
                  exp_dat[p][r][g] = pv[p][r][g];
                  mask[p][r][g]    = '1;
               end
         end
      end
      check($sformatf("c%0d_s_rdy", cyc), s_rdy, exp_srdy);
      check($sformatf("c%0d_bsk_vld", cyc), bsk_vld, exp_vld);
      check($sformatf("c%0d_bsk_data", cyc), bsk & mask, exp_dat);
      check($sformatf("c%0d_error", cyc), error, ERR_EN && viol_prev);
      viol = 1'b0;
      for (int p = 0; p < PSI; p++)
         for (int r = 0; r < R; r++) begin
            if (exp_vld[p][r][0] && (bsk_rdy[p][r][0] != bsk_rdy[0][0][0])) viol = 1'b1;
            for (int g = 1; g < K; g++)
               if (exp_vld[p][r][g] && !bsk_rdy[p][r][g]) viol = 1'b1;
         end
      push = s_vld && exp_srdy;
      pop  = (q.size() > 0) && bsk_rdy[0][0][0];
      @(posedge clk);
      if (pop) begin
         pop_at[cyc] = 1'b1;
         pop_v[cyc]  = q.pop_front();
      end
      if (push) q.push_back(s_bsk);
      rdy_en_m  = 1'b1;
      viol_prev = viol;
      cyc++;
      @(negedge clk);
   endtask

   // Asserts reset in the middle of a cycle, checks outputs drop at once, releases on a negedge.
   task automatic do_reset();
      #2 a_rst_n = 1'b0;
      s_vld = 1'b0;
      #1;
      check("rst_bsk_vld", bsk_vld, '0);
      check("rst_s_rdy", s_rdy, 1'b0);
      check("rst_error", error, 1'b0);
      q.delete();
      pop_at.delete();
      pop_v.delete();
      rdy_en_m  = 1'b0;
      viol_prev = 1'b0;
      @(posedge clk);
      @(negedge clk);
      a_rst_n = 1'b1;
   endtask

   function automatic lane_bits_t mk_rdy(input row_t rw);
      lane_bits_t b = '1;
      for (int p = 0; p < PSI; p++)
         for (int r = 0; r < R; r++)
            b[p][r][0] = rw.r_ref;
      b[3][1][0] = rw.r_3_1;
      b[1][0][1] = rw.r_1_0_g1;
      return b;
   endfunction

   bsk_vect_t vec [9];
   row_t      tbl [30];

   initial begin
      lane_bits_t ev;
      bsk_vect_t  vn;

      tbl = '{
         // single vector
         '{0,0,1,1,1, 0,0,0,0}, '{1,0,1,1,1, 1,0,0,0}, '{0,0,1,1,1, 1,1,0,0},
         '{0,0,1,1,1, 1,0,1,0}, '{0,0,1,1,1, 1,0,0,0},
         // fill and drain
         '{1,1,0,0,1, 1,0,0,0}, '{1,2,0,0,1, 1,1,0,0}, '{1,3,0,0,1, 1,1,0,0},
         '{1,4,0,0,1, 1,1,0,0}, '{1,5,0,0,1, 0,1,0,0}, '{0,0,1,1,1, 0,1,0,0},
         '{0,0,1,1,1, 1,1,1,0}, '{0,0,1,1,1, 1,1,1,0}, '{0,0,1,1,1, 1,1,1,0},
         '{0,0,1,1,1, 1,0,1,0}, '{0,0,1,1,1, 1,0,0,0},
         // skew violation on lane [1][0] column 1
         '{1,6,1,1,1, 1,0,0,0}, '{0,0,1,1,1, 1,1,0,0}, '{0,0,1,1,0, 1,0,1,0},
         '{0,0,1,1,1, 1,0,0,1}, '{0,0,1,1,1, 1,0,0,0},
         // lane [3][1] low while reference high: pop still happens
         '{1,7,1,1,1, 1,0,0,0}, '{0,0,1,0,1, 1,1,0,0}, '{0,0,1,1,1, 1,0,1,1},
         '{0,0,1,1,1, 1,0,0,0},
         // lane [3][1] high while reference low: no pop
         '{1,8,0,1,1, 1,0,0,0}, '{0,0,0,1,1, 1,1,0,0}, '{0,0,1,1,1, 1,1,0,1},
         '{0,0,1,1,1, 1,0,1,0}, '{0,0,1,1,1, 1,0,0,0}
      };
      for (int i = 0; i < 9; i++) vec[i] = rand_vec();

      s_vld = 1'b0; s_bsk = '0; bsk_rdy = '1;
      do_reset();

      // Directed table, checked against hand-derived constants and the model.
      for (int i = 0; i < 30; i++) begin
         s_vld   = tbl[i].s_vld;
         s_bsk   = vec[tbl[i].vid];
         bsk_rdy = mk_rdy(tbl[i]);
         #1;
         ev = '0;
         for (int p = 0; p < PSI; p++)
            for (int r = 0; r < R; r++) begin
               ev[p][r][0] = tbl[i].exp_v0;
               for (int g = 1; g < K; g++) ev[p][r][g] = tbl[i].exp_v1;
            end
         check($sformatf("tbl%0d_s_rdy", i), s_rdy, tbl[i].exp_s_rdy);
         check($sformatf("tbl%0d_vld", i), bsk_vld, ev);
         check($sformatf("tbl%0d_err", i), error, ERR_EN && tbl[i].exp_err);
         tick();
      end

      // Continuous stream of 20 vectors with every ready high.
      bsk_rdy = '1;
      for (int i = 0; i < 20; i++) begin
         s_vld = 1'b1;
         s_bsk = rand_vec();
         tick();
      end
      s_vld = 1'b0;
      repeat (3) tick();

      // Mid-stream reset: 3 vectors queued and a column-1 word in flight.
      for (int p = 0; p < PSI; p++)
         for (int r = 0; r < R; r++) bsk_rdy[p][r][0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_vld = 1'b1;
         s_bsk = rand_vec();
         tick();
      end
      s_vld = 1'b0;
      bsk_rdy = '1;
      tick();
      #1;
      check("pre_rst_col1_vld", bsk_vld[0][0][1], 1'b1);
      check("pre_rst_col0_vld", bsk_vld[0][0][0], 1'b1);
      do_reset();
      tick();
      vn = rand_vec();
      s_vld = 1'b1;
      s_bsk = vn;
      tick();
      s_vld = 1'b0;
      s_bsk = '0;
      #1;
      check("post_rst_vld0", bsk_vld[0][0][0], 1'b1);
      check("post_rst_head", bsk[2][1][0], vn[2][1][0]);
      tick();
      tick();

      // Randomized traffic with occasional protocol violations.
      for (int i = 0; i < 400; i++) begin
         bit rf;
         s_vld = ($urandom_range(0, 3) != 0);
         s_bsk = rand_vec();
         rf = ($urandom_range(0, 3) != 0);
         bsk_rdy = '1;
         for (int p = 0; p < PSI; p++)
            for (int r = 0; r < R; r++) bsk_rdy[p][r][0] = rf;
         if ($urandom_range(0, 19) == 0)
            bsk_rdy[$urandom_range(0, PSI-1)][$urandom_range(0, R-1)][0] = ~rf;
         if ($urandom_range(0, 19) == 0)
            bsk_rdy[$urandom_range(0, PSI-1)][$urandom_range(0, R-1)][$urandom_range(0, K-1)] = 1'b0;
         tick();
      end

      s_vld = 1'b0;
      bsk_rdy = '1;
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
